// File: rtl/rv_mem_pkg.sv
// Shared owner tag and memory control codes for the unified-memory arbiter.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [2:0] CTRL_NONE = 3'b000;
  localparam logic [2:0] CTRL_B    = 3'b001;
  localparam logic [2:0] CTRL_H    = 3'b010;
  localparam logic [2:0] CTRL_D    = 3'b011;
  localparam logic [2:0] CTRL_W    = 3'b100;
  localparam logic [2:0] CTRL_BU   = 3'b101;
  localparam logic [2:0] CTRL_HU   = 3'b110;
  localparam logic [2:0] CTRL_WU   = 3'b111;

  // A data request that asks to read and write at once cannot be issued.
  function automatic logic is_illegal(input logic [2:0] rd_ctrl, input logic [2:0] wr_ctrl);
    return (rd_ctrl != CTRL_NONE) && (wr_ctrl != CTRL_NONE);
  endfunction

endpackage

// File: rtl/rv_mem_prio_sel.sv
// Data-over-fetch grant selection; a waiting fetch wins once the data streak
// reaches MAX_D_STREAK.
module rv_mem_prio_sel
  import rv_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = 3
) (
  input  logic             i_if_req,
  input  logic             i_d_req,
  input  logic [CNT_W-1:0] i_streak,
  output logic             o_gnt_if,
  output logic             o_gnt_d,
  output logic [CNT_W-1:0] o_streak_nxt
);

  logic w_sat;

  assign w_sat = (i_streak >= CNT_W'(MAX_D_STREAK));

  always_comb begin
    o_gnt_d      = i_d_req && !(i_if_req && w_sat);
    o_gnt_if     = i_if_req && !o_gnt_d;
    o_streak_nxt = '0;
    // Only data grants that make a fetch wait extend the streak; w_sat is
    // false here, so the count can never pass MAX_D_STREAK.
    if (i_if_req && o_gnt_d) begin
      o_streak_nxt = i_streak + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Unified-memory arbiter: one synchronous single-port memory shared by the
// instruction-fetch and data ports, with read responses routed back by owner.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [2:0]        i_d_rd_ctrl,
  input  logic [2:0]        i_d_wr_ctrl,
  input  logic [63:0]       i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [63:0]       o_d_rdata,
  output logic              o_d_err,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [2:0]        o_m_rd_ctrl,
  output logic [2:0]        o_m_wr_ctrl,
  output logic [63:0]       o_m_wdata,
  input  logic [63:0]       i_m_rdata
);

  logic [CNT_W-1:0] r_streak;
  logic [CNT_W-1:0] w_streak_nxt;
  owner_e           r_owner;
  owner_e           w_owner_nxt;
  logic             r_if_hi;
  logic             w_gnt_if;
  logic             w_gnt_d;
  logic             w_d_illegal;
  logic             w_d_read;
  logic             w_unused_addr;

  rv_mem_prio_sel #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .CNT_W        (CNT_W)
  ) u_prio_sel (
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .i_streak     (r_streak),
    .o_gnt_if     (w_gnt_if),
    .o_gnt_d      (w_gnt_d),
    .o_streak_nxt (w_streak_nxt)
  );

  // Fetches are always word aligned; the low byte-offset bits carry nothing.
  assign w_unused_addr = ^i_if_addr[1:0];

  assign w_d_illegal = is_illegal(i_d_rd_ctrl, i_d_wr_ctrl);
  assign w_d_read    = (i_d_rd_ctrl != CTRL_NONE) && !w_d_illegal;

  assign o_if_gnt = w_gnt_if && !i_rst;
  assign o_d_gnt  = w_gnt_d && !i_rst;
  assign o_d_err  = o_d_gnt && w_d_illegal;

  always_comb begin
    o_m_addr    = '0;
    o_m_rd_ctrl = CTRL_NONE;
    o_m_wr_ctrl = CTRL_NONE;
    o_m_wdata   = '0;
    w_owner_nxt = OWN_NONE;
    if (o_d_gnt) begin
      o_m_addr  = i_d_addr;
      o_m_wdata = i_d_wdata;
      if (!w_d_illegal) begin
        o_m_rd_ctrl = i_d_rd_ctrl;
        o_m_wr_ctrl = i_d_wr_ctrl;
      end
      if (w_d_read) begin
        w_owner_nxt = OWN_D;
      end
    end else if (o_if_gnt) begin
      o_m_addr    = {i_if_addr[ADDR_W-1:3], 3'b000};
      o_m_rd_ctrl = CTRL_D;
      w_owner_nxt = OWN_IF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_streak <= '0;
      r_owner  <= OWN_NONE;
      r_if_hi  <= 1'b0;
    end else begin
      r_streak <= w_streak_nxt;
      r_owner  <= w_owner_nxt;
      if (w_gnt_if) begin
        r_if_hi <= i_if_addr[2];
      end
    end
  end

  // Gating with i_rst drops a response that was in flight when reset hit.
  assign o_if_rvalid = !i_rst && (r_owner == OWN_IF);
  assign o_if_rdata  = r_if_hi ? i_m_rdata[63:32] : i_m_rdata[31:0];
  assign o_d_rvalid  = !i_rst && (r_owner == OWN_D);
  assign o_d_rdata   = i_m_rdata;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model with its own memory image.
module tb_rv_mem_arbiter;
  import rv_mem_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic        if_req;
  logic [63:0] if_addr;
  logic        d_req;
  logic [63:0] d_addr;
  logic [2:0]  d_rd;
  logic [2:0]  d_wr;
  logic [63:0] d_wdata;
  logic [63:0] m_rdata;

  logic        o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_d_err;
  logic [31:0] o_if_rdata;
  logic [63:0] o_d_rdata, o_m_addr, o_m_wdata;
  logic [2:0]  o_m_rd_ctrl, o_m_wr_ctrl;

  rv_mem_arbiter #(.ADDR_W(64), .MAX_D_STREAK(MAXS), .CNT_W(3)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_d_req     (d_req),
    .i_d_addr    (d_addr),
    .i_d_rd_ctrl (d_rd),
    .i_d_wr_ctrl (d_wr),
    .i_d_wdata   (d_wdata),
    .o_d_gnt     (o_d_gnt),
    .o_d_rvalid  (o_d_rvalid),
    .o_d_rdata   (o_d_rdata),
    .o_d_err     (o_d_err),
    .o_m_addr    (o_m_addr),
    .o_m_rd_ctrl (o_m_rd_ctrl),
    .o_m_wr_ctrl (o_m_wr_ctrl),
    .o_m_wdata   (o_m_wdata),
    .i_m_rdata   (m_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'(i) * 32'h9E3779B1, ~(32'(i) * 32'h85EBCA6B)};
  endfunction

  // Memory the DUT actually drives: write on the edge, registered read.
  logic [63:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= pat(i);
    end else if (o_m_wr_ctrl != 3'b000) begin
      env_mem[o_m_addr[10:3]] <= o_m_wdata;
    end
    if (o_m_rd_ctrl != 3'b000) m_rdata <= env_mem[o_m_addr[10:3]];
  end

  // Reference model: memory image, data-run length, one pending response.
  logic [63:0] mdl_mem [256];
  bit          chk_en = 1'b0;
  bit          mdl_if_gnt, mdl_d_gnt;
  int          d_run;
  bit          pend_if, pend_d;
  logic [31:0] pend_if_data;
  logic [63:0] pend_d_data;

  always @(negedge clk) begin : cmp
    bit fetch_wins, ig, dg, ill;
    if (chk_en) begin
      if (rst) begin
        chk("rst_if_gnt",    64'(o_if_gnt), 64'd0);
        chk("rst_d_gnt",     64'(o_d_gnt), 64'd0);
        chk("rst_d_err",     64'(o_d_err), 64'd0);
        chk("rst_if_rvalid", 64'(o_if_rvalid), 64'd0);
        chk("rst_d_rvalid",  64'(o_d_rvalid), 64'd0);
        chk("rst_m_rd",      64'(o_m_rd_ctrl), 64'd0);
        chk("rst_m_wr",      64'(o_m_wr_ctrl), 64'd0);
        chk("rst_m_addr",    o_m_addr, 64'd0);
        chk("rst_m_wdata",   o_m_wdata, 64'd0);
        d_run = 0; pend_if = 0; pend_d = 0; mdl_if_gnt = 0; mdl_d_gnt = 0;
      end else begin
        chk("if_rvalid", 64'(o_if_rvalid), 64'(pend_if));
        if (pend_if) chk("if_rdata", 64'(o_if_rdata), 64'(pend_if_data));
        chk("d_rvalid", 64'(o_d_rvalid), 64'(pend_d));
        if (pend_d) chk("d_rdata", o_d_rdata, pend_d_data);

        fetch_wins = if_req && (!d_req || d_run >= MAXS);
        ig  = fetch_wins;
        dg  = d_req && !fetch_wins;
        ill = dg && (d_rd != 3'd0) && (d_wr != 3'd0);
        chk("if_gnt", 64'(o_if_gnt), 64'(ig));
        chk("d_gnt",  64'(o_d_gnt), 64'(dg));
        chk("d_err",  64'(o_d_err), 64'(ill));
        if (ig) begin
          chk("m_addr_if", o_m_addr, {if_addr[63:3], 3'b000});
          chk("m_rd_if",   64'(o_m_rd_ctrl), 64'd3);
          chk("m_wr_if",   64'(o_m_wr_ctrl), 64'd0);
        end else if (dg && !ill) begin
          chk("m_addr_d", o_m_addr, d_addr);
          chk("m_rd_d",   64'(o_m_rd_ctrl), 64'(d_rd));
          chk("m_wr_d",   64'(o_m_wr_ctrl), 64'(d_wr));
          if (d_wr != 3'd0) chk("m_wdata_d", o_m_wdata, d_wdata);
        end else begin
          chk("m_rd_idle", 64'(o_m_rd_ctrl), 64'd0);
          chk("m_wr_idle", 64'(o_m_wr_ctrl), 64'd0);
        end

        pend_if = ig;
        if (ig) pend_if_data = if_addr[2] ? mdl_mem[if_addr[10:3]][63:32]
                                          : mdl_mem[if_addr[10:3]][31:0];
        pend_d = dg && !ill && (d_rd != 3'd0);
        if (pend_d) pend_d_data = mdl_mem[d_addr[10:3]];
        if (dg && !ill && d_wr != 3'd0) mdl_mem[d_addr[10:3]] = d_wdata;
        d_run = (if_req && dg) ? d_run + 1 : 0;
        mdl_if_gnt = ig;
        mdl_d_gnt  = dg;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_rd = 3'd0; d_wr = 3'd0;
  endtask

  task automatic dstore(input logic [63:0] a, input logic [63:0] v);
    step(); d_req = 1'b1; d_addr = a; d_rd = 3'd0; d_wr = 3'd3; d_wdata = v;
    #2 chk("store_gnt", 64'(o_d_gnt), 64'd1);
    step(); idle();
    #2 chk("store_no_rvalid", 64'(o_d_rvalid), 64'd0);
  endtask

  task automatic contend(input int n, input string exp_log, input string nm);
    string lg;
    lg = "";
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      if_req = 1'b1; if_addr = 64'h100; d_req = 1'b1; d_addr = 64'h200; d_rd = 3'd3; d_wr = 3'd0;
      #2 lg = {lg, o_d_gnt ? "D" : (o_if_gnt ? "I" : "-")};
    end
    checks++;
    if (lg != exp_log) begin
      failures++;
      $display("FAIL %s actual=%s expected=%s", nm, lg, exp_log);
    end
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1; idle();
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = pat(i);
    chk_en = 1'b1;

    step(); if_req = 1'b1; d_req = 1'b1; d_rd = 3'd3;
    #2 chk("rst_gate_if", 64'(o_if_gnt), 64'd0);
    chk("rst_gate_d", 64'(o_d_gnt), 64'd0);
    step(); step(); rst = 1'b0; mem_init = 1'b0; idle();

    dstore(64'h100, 64'hAAAABBBB11112222);
    dstore(64'h000, 64'h0123456789ABCDEF);
    dstore(64'h008, 64'hFEDCBA9876543210);

    // Fetch only, upper then lower half.
    step(); if_req = 1'b1; if_addr = 64'h104;
    #2 chk("f_gnt", 64'(o_if_gnt), 64'd1);
    chk("f_m_addr", o_m_addr, 64'h100);
    chk("f_m_rd", 64'(o_m_rd_ctrl), 64'd3);
    step(); if_addr = 64'h100;
    #2 chk("f_rvalid_hi", 64'(o_if_rvalid), 64'd1);
    chk("f_rdata_hi", 64'(o_if_rdata), 64'hAAAABBBB);
    step(); idle();
    #2 chk("f_rvalid_lo", 64'(o_if_rvalid), 64'd1);
    chk("f_rdata_lo", 64'(o_if_rdata), 64'h11112222);

    // Store then load.
    dstore(64'h200, 64'hDEADBEEFCAFEF00D);
    step(); d_req = 1'b1; d_addr = 64'h200; d_rd = 3'd3; d_wr = 3'd0;
    #2 chk("ld_gnt", 64'(o_d_gnt), 64'd1);
    step(); idle();
    #2 chk("ld_rvalid", 64'(o_d_rvalid), 64'd1);
    chk("ld_rdata", o_d_rdata, 64'hDEADBEEFCAFEF00D);

    step();
    contend(10, "DDDDIDDDDI", "contention_pattern");
    step(); idle();

    // Illegal request.
    step(); d_req = 1'b1; d_addr = 64'h40; d_rd = 3'd1; d_wr = 3'd1;
    #2 chk("ill_gnt", 64'(o_d_gnt), 64'd1);
    chk("ill_err", 64'(o_d_err), 64'd1);
    chk("ill_m_rd", 64'(o_m_rd_ctrl), 64'd0);
    chk("ill_m_wr", 64'(o_m_wr_ctrl), 64'd0);
    step(); idle();
    #2 chk("ill_no_rvalid", 64'(o_d_rvalid), 64'd0);
    chk("ill_err_pulse", 64'(o_d_err), 64'd0);

    // Reset right after a fetch grant drops its response.
    step(); if_req = 1'b1; if_addr = 64'h8;
    #2 chk("rf_gnt", 64'(o_if_gnt), 64'd1);
    step(); if_req = 1'b0; rst = 1'b1;
    #2 chk("rf_rvalid_in_rst", 64'(o_if_rvalid), 64'd0);
    step(); rst = 1'b0;
    #2 chk("rf_rvalid_after", 64'(o_if_rvalid), 64'd0);

    // Reset during a data streak clears it.
    step();
    contend(3, "DDD", "pre_reset_streak");
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    contend(5, "DDDDI", "post_reset_streak");
    step(); idle();

    // Back-to-back fetches.
    step(); if_req = 1'b1; if_addr = 64'h0;
    #2 chk("bb_gnt0", 64'(o_if_gnt), 64'd1);
    step(); if_addr = 64'h4;
    #2 chk("bb_gnt1", 64'(o_if_gnt), 64'd1);
    chk("bb_rv0", 64'(o_if_rvalid), 64'd1);
    chk("bb_rd0", 64'(o_if_rdata), 64'h89ABCDEF);
    step(); if_addr = 64'h8;
    #2 chk("bb_gnt2", 64'(o_if_gnt), 64'd1);
    chk("bb_rv1", 64'(o_if_rvalid), 64'd1);
    chk("bb_rd1", 64'(o_if_rdata), 64'h01234567);
    step(); idle();
    #2 chk("bb_rv2", 64'(o_if_rvalid), 64'd1);
    chk("bb_rd2", 64'(o_if_rdata), 64'h76543210);

    // Random traffic; requests are held until the model says granted.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (!if_req || mdl_if_gnt) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = 64'($urandom_range(0, 511)) << 2;
      end
      if (!d_req || mdl_d_gnt) begin
        int k;
        d_req = ($urandom_range(0, 3) != 0);
        d_addr = 64'($urandom_range(0, 2047));
        d_wdata = {$urandom, $urandom};
        k = $urandom_range(0, 9);
        if (k == 0) begin
          d_rd = 3'($urandom_range(1, 7)); d_wr = 3'd3;
        end else if (k == 1) begin
          d_rd = 3'd0; d_wr = 3'd0;
        end else if (k < 6) begin
          d_rd = 3'($urandom_range(1, 7)); d_wr = 3'd0;
        end else begin
          d_rd = 3'd0; d_wr = 3'd3;
        end
      end
    end

    step(); rst = 1'b0; idle();
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one unified single-port memory (synchronous read, 1-cycle latency) between the CPU instruction-fetch port and the data port.
- Sits between RVCPU and mem; lets the core run from a single memory instead of separate im/dm ports.
- Uses fixed data-over-fetch priority, with a streak counter that bounds fetch starvation.
- Issues per-port grants and routes read responses back to their owners.

Parameters:
- ADDR_W, 64, address width of all ports.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits; must be ≥1.
- CNT_W, 3, streak counter width; must satisfy 2^CNT_W > MAX_D_STREAK.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid, 1 cycle after if_gnt.
- if_rdata  out  32  instruction word.
- d_req  in  1  data request; held until granted.
- d_addr  in  ADDR_W  data byte address.
- d_rd_ctrl  in  3  read size/sign code; 0 means no read.
- d_wr_ctrl  in  3  write size code; 0 means no write.
- d_wdata  in  64  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, 1 cycle after a read grant.
- d_rdata  out  64  load data, passed through from memory.
- d_err  out  1  one-cycle pulse: illegal data request consumed.
- m_addr  out  ADDR_W  memory address.
- m_rd_ctrl  out  3  memory read code.
- m_wr_ctrl  out  3  memory write code; write commits on the clk edge.
- m_wdata  out  64  memory write data.
- m_rdata  in  64  memory read data, valid the cycle after the address.

Behaviour:
- Reset (synchronous, active-high): all gnt, rvalid and err outputs 0; m_rd_ctrl=0; m_wr_ctrl=0; m_addr=0; m_wdata=0; streak counter=0; response owner=NONE.
- Arbitration (combinational, each cycle):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both, streak<MAX_D_STREAK: grant data, streak+1.
  - Both, streak==MAX_D_STREAK: grant fetch, streak cleared to 0.
  - Any cycle with a fetch grant, or with if_req=0, clears streak.
  - Exactly one grant per cycle at most.
- Issue (same cycle as grant):
  - Data grant: m_* = d_* fields.
  - Fetch grant: m_addr={if_addr[ADDR_W-1:3],3'b000}, m_rd_ctrl=3'b011 (64-bit read), m_wr_ctrl=0.
  - No grant: m_rd_ctrl=0 and m_wr_ctrl=0.
- Response: a registered owner tag {NONE, IF, D} plus a registered if_addr[2].
  - Next cycle, owner IF: if_rvalid=1; if_rdata = m_rdata[63:32] when the latched bit is 1, else m_rdata[31:0].
  - Next cycle, owner D with a read: d_rvalid=1, d_rdata=m_rdata.
  - Writes produce no rvalid; a write is complete at d_gnt.
- Throughput: back-to-back grants every cycle. A response (cycle N+1) and a new grant (cycle N+1) may coincide; both are honoured.
- Illegal data request: d_rd_ctrl≠0 and d_wr_ctrl≠0 together.
  - Arbitrated normally; when selected: d_gnt=1 and d_err=1.
  - Memory sees m_rd_ctrl=0 and m_wr_ctrl=0; no d_rvalid follows.
- d_req with both ctrl fields 0: treated as a no-op grant; no memory access, no rvalid, no err.
- Requesters must keep address/ctrl/data stable while req is high and gnt is low. The arbiter does not latch request fields.
- Reset mid-transaction: an outstanding response is dropped (rvalid stays 0 the cycle after rst). The counter clears.
- Streak counter saturates at MAX_D_STREAK and never wraps.

Decomposition:
- Shared package rv_mem_pkg:
  - Owner enum {OWN_NONE, OWN_IF, OWN_D}.
  - Ctrl code constants: CTRL_NONE=3'b000, CTRL_D=3'b011 (doubleword), plus the byte/half/word codes already used by mem.
- One sub-module: rv_mem_prio_sel, the combinational priority-plus-streak grant logic. Streak register and response tracking stay in the top level.

Test Plan:
- Fetch only: if_req=1, if_addr=0x104, m_rdata=0xAAAA_BBBB_1111_2222.
  - Required: if_gnt same cycle; m_addr=0x100; m_rd_ctrl=3.
  - Required: if_rvalid next cycle with if_rdata=0xAAAABBBB.
  - Repeat with if_addr=0x100 -> if_rdata=0x11112222.
- Data store then load to 0x200: wr_ctrl=3 with d_wdata=0xDEADBEEF_CAFEF00D, then rd_ctrl=3.
  - Required: no d_rvalid after the store.
  - Required: d_rvalid one cycle after the load grant with d_rdata=0xDEADBEEFCAFEF00D.
- Contention, MAX_D_STREAK=4: d_req and if_req held high for 10 cycles.
  - Required grant pattern: D,D,D,D,IF,D,D,D,D,IF.
  - Required: each response routed to the correct port.
- Illegal request: d_rd_ctrl=1 with d_wr_ctrl=1.
  - Required: d_gnt=1 and d_err=1 for one cycle; m_rd_ctrl=0 and m_wr_ctrl=0; no d_rvalid.
- Reset mid-operation: assert rst in the cycle after a fetch grant.
  - Required: if_rvalid=0 next cycle; all outputs at reset values; streak=0 (the next contention grants D first).
- Back-to-back fetches to 0x0, 0x4, 0x8, one per cycle.
  - Required: if_gnt high in 3 consecutive cycles; if_rvalid high in the 3 following cycles.
  - Required: correct halves returned (low, high, low).
